// File: rtl/io_output_bank_if.sv
// Bus bundle for the gpgpu io_* port as seen by a memory-mapped peripheral.
interface io_output_bank_if;
    logic        io_write_en;
    logic        io_read_en;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_read_valid;

    modport master (
        output io_write_en,
        output io_read_en,
        output io_address,
        output io_write_data,
        input  io_read_data,
        input  io_read_valid
    );

    modport slave (
        input  io_write_en,
        input  io_read_en,
        input  io_address,
        input  io_write_data,
        output io_read_data,
        output io_read_valid
    );
endinterface

// File: rtl/io_output_bank.sv
// Memory-mapped output register bank: DATA/SET/CLEAR aliases per channel plus a
// write-to-clear event counter, with registered one-cycle-latency readback.
module io_output_bank #(
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int          NUM_CHANNELS  = 6,
    parameter int          CHANNEL_WIDTH = 18,
    parameter logic [31:0] RESET_VALUE   = 32'h0,
    parameter int          COUNTER_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    io_output_bank_if.slave                       bus,
    input  logic                                  event_in,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] channel_out
);

    localparam logic [4:0]               NUM_CH   = 5'(NUM_CHANNELS);
    localparam logic [CHANNEL_WIDTH-1:0] CH_RESET = RESET_VALUE[CHANNEL_WIDTH-1:0];

    logic [CHANNEL_WIDTH-1:0] channel_q [NUM_CHANNELS];
    logic [CHANNEL_WIDTH-1:0] channel_d [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] counter_q;
    logic [COUNTER_WIDTH-1:0] counter_d;
    logic [31:0]              readData_q;
    logic [31:0]              readData_d;
    logic                     readValid_q;

    logic                     inWindow;
    logic [1:0]               region;
    logic [3:0]               chanIdx;
    logic                     chanHit;
    logic                     countHit;
    logic [CHANNEL_WIDTH-1:0] writeBits;
    logic                     unusedBits;

    // Offset bits [7:6] pick DATA/SET/CLEAR/COUNT, [5:2] pick the channel; the
    // window test relies on BASE_ADDR being 256-byte aligned.
    assign inWindow   = (bus.io_address[31:8] == BASE_ADDR[31:8]);
    assign region     = bus.io_address[7:6];
    assign chanIdx    = bus.io_address[5:2];
    assign chanHit    = inWindow && (region != 2'd3) && ({1'b0, chanIdx} < NUM_CH);
    assign countHit   = inWindow && (region == 2'd3) && (chanIdx == 4'd0);
    assign writeBits  = bus.io_write_data[CHANNEL_WIDTH-1:0];
    assign unusedBits = ^{bus.io_write_data, bus.io_address[1:0]};

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            channel_d[i] = channel_q[i];
            if (bus.io_write_en && chanHit && (chanIdx == 4'(i))) begin
                case (region)
                    2'd0:    channel_d[i] = writeBits;
                    2'd1:    channel_d[i] = channel_q[i] | writeBits;
                    2'd2:    channel_d[i] = channel_q[i] & ~writeBits;
                    default: channel_d[i] = channel_q[i];
                endcase
            end
        end
    end

    // A clear in the same cycle as an event wins; the event is dropped.
    always_comb begin
        counter_d = counter_q;
        if (bus.io_write_en && countHit) begin
            counter_d = '0;
        end else if (event_in) begin
            counter_d = counter_q + COUNTER_WIDTH'(1);
        end
    end

    always_comb begin
        readData_d = readData_q;
        if (bus.io_read_en) begin
            readData_d = '0;
            if (countHit) begin
                readData_d = 32'(counter_q);
            end
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (chanHit && (chanIdx == 4'(i))) begin
                    readData_d = 32'(channel_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                channel_q[i] <= CH_RESET;
            end
            counter_q   <= '0;
            readData_q  <= '0;
            readValid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                channel_q[i] <= channel_d[i];
            end
            counter_q   <= counter_d;
            readData_q  <= readData_d;
            readValid_q <= bus.io_read_en;
        end
    end

    assign bus.io_read_data  = readData_q;
    assign bus.io_read_valid = readValid_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gPack
        assign channel_out[g*CHANNEL_WIDTH +: CHANNEL_WIDTH] = channel_q[g];
    end

endmodule

// File: tb/tb_io_output_bank.sv
// Self-checking bench for io_output_bank: directed table, hand sequences for counter,
// wrap and reset corners, and randomized traffic against an arithmetic reference model.
module tb_io_output_bank;

    localparam logic [31:0]     BASE_A = 32'h0004_0200;
    localparam int              NUM_A  = 6;
    localparam int              CW_A   = 18;
    localparam int              CNTW_A = 32;
    localparam logic [31:0]     MASK_A = 32'((64'd1 << CW_A) - 64'd1);
    localparam longint unsigned CMOD_A = 64'd1 << CNTW_A;

    localparam logic [31:0] BASE_B  = 32'h0;
    localparam int          NUM_B   = 6;
    localparam int          CW_B    = 7;
    localparam int          CNTW_B  = 4;
    localparam logic [31:0] RESET_B = 32'h7F;

    logic clk;
    logic reset;
    logic eventA;
    logic eventB;
    logic [NUM_A*CW_A-1:0] channelOutA;
    logic [NUM_B*CW_B-1:0] channelOutB;

    io_output_bank_if busA ();
    io_output_bank_if busB ();

    int checks = 0;
    int errors = 0;

    logic [31:0]     mCh [NUM_A];
    longint unsigned mCount;
    logic [31:0]     mReadData;
    logic            mReadValid;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [31:0] off;
        logic [31:0] wd;
        int          ch;
        logic [31:0] expCh;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs [16];

    io_output_bank #(
        .BASE_ADDR(BASE_A), .NUM_CHANNELS(NUM_A), .CHANNEL_WIDTH(CW_A),
        .RESET_VALUE(32'h0), .COUNTER_WIDTH(CNTW_A)
    ) dutA (
        .clk(clk), .reset(reset), .bus(busA), .event_in(eventA), .channel_out(channelOutA)
    );

    io_output_bank #(
        .BASE_ADDR(BASE_B), .NUM_CHANNELS(NUM_B), .CHANNEL_WIDTH(CW_B),
        .RESET_VALUE(RESET_B), .COUNTER_WIDTH(CNTW_B)
    ) dutB (
        .clk(clk), .reset(reset), .bus(busB), .event_in(eventB), .channel_out(channelOutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sliceA(input int i);
        return 32'(channelOutA[i*CW_A +: CW_A]);
    endfunction

    function automatic logic [31:0] sliceB(input int i);
        return 32'(channelOutB[i*CW_B +: CW_B]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_A; i++) mCh[i] = 32'h0;
        mCount     = 0;
        mReadData  = 32'h0;
        mReadValid = 1'b0;
    endtask

    // Reference for one clock of traffic on dutA; reads see the state before this cycle's write.
    task automatic modelStep(input logic we, input logic re, input logic [31:0] addr,
                             input logic [31:0] wd, input logic ev);
        longint unsigned off;
        int  region;
        int  idx;
        bit  mapped;
        bit  cleared;
        off     = longint'({32'd0, addr}) - longint'({32'd0, BASE_A});
        mapped  = (off < 256);
        region  = mapped ? int'(off / 64) : 0;
        idx     = mapped ? int'((off % 64) / 4) : 0;
        cleared = 1'b0;
        mReadValid = re;
        if (re) begin
            mReadData = 32'h0;
            if (mapped && region < 3 && idx < NUM_A) mReadData = mCh[idx];
            else if (mapped && region == 3 && idx == 0) mReadData = 32'(mCount);
        end
        if (we && mapped) begin
            if (region < 3 && idx < NUM_A) begin
                if (region == 0) mCh[idx] = wd & MASK_A;
                else if (region == 1) mCh[idx] = (mCh[idx] | wd) & MASK_A;
                else mCh[idx] = mCh[idx] & ~wd;
            end else if (region == 3 && idx == 0) begin
                mCount  = 0;
                cleared = 1'b1;
            end
        end
        if (ev && !cleared) mCount = (mCount + 1) % CMOD_A;
    endtask

    task automatic applyStimulus(input int sel, input logic we, input logic re,
                                 input logic [31:0] addr, input logic [31:0] wd, input logic ev);
        if (sel == 0) begin
            busA.io_write_en = we; busA.io_read_en = re;
            busA.io_address = addr; busA.io_write_data = wd; eventA = ev;
        end else begin
            busB.io_write_en = we; busB.io_read_en = re;
            busB.io_address = addr; busB.io_write_data = wd; eventB = ev;
        end
        @(posedge clk);
        if (sel == 0) modelStep(we, re, addr, wd, ev);
        @(negedge clk);
        busA.io_write_en = 1'b0; busA.io_read_en = 1'b0; eventA = 1'b0;
        busB.io_write_en = 1'b0; busB.io_read_en = 1'b0; eventB = 1'b0;
    endtask

    task automatic checkAllA(input string tag);
        for (int i = 0; i < NUM_A; i++)
            checkOutput($sformatf("%s A ch%0d", tag, i), sliceA(i), mCh[i]);
        checkOutput($sformatf("%s A valid", tag), 32'(busA.io_read_valid), 32'(mReadValid));
        checkOutput($sformatf("%s A rdata", tag), busA.io_read_data, mReadData);
    endtask

    function automatic logic [31:0] randomOffset();
        case ($urandom_range(0, 9))
            0, 1, 2: return 32'(4 * $urandom_range(0, 7));
            3:       return 32'(8'h40 + 4 * $urandom_range(0, 7));
            4:       return 32'(8'h80 + 4 * $urandom_range(0, 7));
            5:       return 32'(8'hC0 + 4 * $urandom_range(0, 1));
            6:       return 32'($urandom_range(0, 255));
            7:       return 32'(12'h100 + 4 * $urandom_range(0, 5));
            8:       return 32'hFFFF_FFFC;
            default: return 32'(4 * $urandom_range(0, 5));
        endcase
    endfunction

    initial begin
        logic [31:0] off;
        busA.io_write_en = 1'b0; busA.io_read_en = 1'b0;
        busA.io_address = 32'h0; busA.io_write_data = 32'h0;
        busB.io_write_en = 1'b0; busB.io_read_en = 1'b0;
        busB.io_address = 32'h0; busB.io_write_data = 32'h0;
        eventA = 1'b0; eventB = 1'b0;
        reset = 1'b1;
        modelReset();

        vecs[0]  = '{"wr DATA1 ones",     1'b1, 1'b0, 32'h04,  32'hFFFF_FFFF, 1, 32'h3FFFF, 32'h0};
        vecs[1]  = '{"rd DATA1",          1'b0, 1'b1, 32'h04,  32'h0,         1, 32'h3FFFF, 32'h0003_FFFF};
        vecs[2]  = '{"wr DATA0",          1'b1, 1'b0, 32'h00,  32'h00F0,      0, 32'h00F0,  32'h0};
        vecs[3]  = '{"wr SET0",           1'b1, 1'b0, 32'h40,  32'h000F,      0, 32'h00FF,  32'h0};
        vecs[4]  = '{"wr CLEAR0",         1'b1, 1'b0, 32'h80,  32'h0030,      0, 32'h00CF,  32'h0};
        vecs[5]  = '{"rd SET0 alias",     1'b0, 1'b1, 32'h40,  32'h0,         0, 32'h00CF,  32'h00CF};
        vecs[6]  = '{"rd CLEAR0 lowbits", 1'b0, 1'b1, 32'h83,  32'h0,         0, 32'h00CF,  32'h00CF};
        vecs[7]  = '{"wr unmapped 0x18",  1'b1, 1'b0, 32'h18,  32'h12345,     5, 32'h0,     32'h0};
        vecs[8]  = '{"rd unmapped 0x18",  1'b0, 1'b1, 32'h18,  32'h0,         5, 32'h0,     32'h0};
        vecs[9]  = '{"wr DATA5",          1'b1, 1'b0, 32'h14,  32'h0002_ABCD, 5, 32'h2ABCD, 32'h0};
        vecs[10] = '{"rd unmapped 0xC4",  1'b0, 1'b1, 32'hC4,  32'h0,         5, 32'h2ABCD, 32'h0};
        vecs[11] = '{"wr outside window", 1'b1, 1'b0, 32'h114, 32'h0,         5, 32'h2ABCD, 32'h0};
        vecs[12] = '{"rd outside window", 1'b0, 1'b1, 32'h114, 32'h0,         5, 32'h2ABCD, 32'h0};
        vecs[13] = '{"rd+wr DATA5",       1'b1, 1'b1, 32'h14,  32'h11111,     5, 32'h11111, 32'h2ABCD};
        vecs[14] = '{"rd COUNT idle",     1'b0, 1'b1, 32'hC0,  32'h0,         5, 32'h11111, 32'h0};
        vecs[15] = '{"rd SET5 alias",     1'b0, 1'b1, 32'h54,  32'h0,         5, 32'h11111, 32'h11111};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NUM_A; i++) checkOutput($sformatf("reset A ch%0d", i), sliceA(i), 32'h0);
        for (int i = 0; i < NUM_B; i++) checkOutput($sformatf("reset B ch%0d", i), sliceB(i), 32'h7F);
        checkOutput("reset A rdata", busA.io_read_data, 32'h0);
        checkOutput("reset A valid", 32'(busA.io_read_valid), 32'h0);
        checkOutput("reset B rdata", busB.io_read_data, 32'h0);
        checkOutput("reset B valid", 32'(busB.io_read_valid), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, vecs[k].we, vecs[k].re, BASE_A + vecs[k].off, vecs[k].wd, 1'b0);
            checkOutput($sformatf("%s ch", vecs[k].name), sliceA(vecs[k].ch), vecs[k].expCh);
            checkOutput($sformatf("%s valid", vecs[k].name), 32'(busA.io_read_valid), 32'(vecs[k].re));
            if (vecs[k].re) checkOutput($sformatf("%s rdata", vecs[k].name), busA.io_read_data, vecs[k].expRd);
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("valid is one pulse", 32'(busA.io_read_valid), 32'h0);
        checkOutput("rdata holds", busA.io_read_data, 32'h11111);

        repeat (5) applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(0, 1'b0, 1'b1, BASE_A + 32'hC0, 32'h0, 1'b0);
        checkOutput("count after 5", busA.io_read_data, 32'd5);
        applyStimulus(0, 1'b1, 1'b0, BASE_A + 32'hC0, 32'hDEAD, 1'b1);
        applyStimulus(0, 1'b0, 1'b1, BASE_A + 32'hC0, 32'h0, 1'b0);
        checkOutput("count clear beats event", busA.io_read_data, 32'd0);
        applyStimulus(0, 1'b0, 1'b1, BASE_A + 32'hC0, 32'h0, 1'b1);
        checkOutput("count read pre-increment", busA.io_read_data, 32'd0);
        applyStimulus(0, 1'b0, 1'b1, BASE_A + 32'hC0, 32'h0, 1'b0);
        checkOutput("count post-increment", busA.io_read_data, 32'd1);

        repeat (17) applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1, 1'b0, 1'b1, BASE_B + 32'hC0, 32'h0, 1'b0);
        checkOutput("B count wrap", busB.io_read_data, 32'd1);
        checkOutput("B count valid", 32'(busB.io_read_valid), 32'h1);
        applyStimulus(1, 1'b1, 1'b0, BASE_B + 32'h18, 32'h0, 1'b0);
        for (int i = 0; i < NUM_B; i++) checkOutput($sformatf("B unmapped wr ch%0d", i), sliceB(i), 32'h7F);
        applyStimulus(1, 1'b0, 1'b1, BASE_B + 32'h18, 32'h0, 1'b0);
        checkOutput("B unmapped rd", busB.io_read_data, 32'h0);
        checkOutput("B unmapped valid", 32'(busB.io_read_valid), 32'h1);
        applyStimulus(1, 1'b1, 1'b0, BASE_B + 32'h88, 32'hFFFF_FF0F, 1'b0);
        checkOutput("B CLEAR2", sliceB(2), 32'h70);
        applyStimulus(1, 1'b0, 1'b1, BASE_B + 32'h08, 32'h0, 1'b0);
        checkOutput("B rd DATA2", busB.io_read_data, 32'h70);

        for (int n = 0; n < 400; n++) begin
            off = randomOffset();
            applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          BASE_A + off + 32'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)));
            checkAllA($sformatf("rand%0d", n));
        end

        busA.io_read_en = 1'b1; busA.io_address = BASE_A + 32'h04;
        busB.io_read_en = 1'b1; busB.io_address = BASE_B + 32'h08;
        @(posedge clk);
        #1 reset = 1'b1;
        busA.io_read_en = 1'b0; busB.io_read_en = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("midreset A valid", 32'(busA.io_read_valid), 32'h0);
        checkOutput("midreset B valid", 32'(busB.io_read_valid), 32'h0);
        checkOutput("midreset A rdata", busA.io_read_data, 32'h0);
        checkOutput("midreset B rdata", busB.io_read_data, 32'h0);
        for (int i = 0; i < NUM_A; i++) checkOutput($sformatf("midreset A ch%0d", i), sliceA(i), 32'h0);
        for (int i = 0; i < NUM_B; i++) checkOutput($sformatf("midreset B ch%0d", i), sliceB(i), 32'h7F);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, BASE_A + 32'hC0, 32'h0, 1'b0);
        checkAllA("post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
